// File: rtl/mesi_line_array.sv
// Direct-mapped array of MESI-tracked cache lines with a CPU requester FSM and a
// snoop port; one instance per cache, between the CPU and the bus arbiter.
module mesi_line_array #(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             cpu_valid,
    input  logic             cpu_write,
    input  logic [IDX_W-1:0] cpu_idx,
    input  logic [TAG_W-1:0] cpu_tag,
    output logic             cpu_ready,
    output logic             cpu_hit,
    output logic             bus_req,
    output logic [2:0]       bus_cmd,
    output logic [IDX_W-1:0] bus_idx,
    output logic [TAG_W-1:0] bus_tag,
    input  logic             bus_gnt,
    input  logic             bus_shared,
    input  logic             snp_valid,
    input  logic [2:0]       snp_cmd,
    input  logic [IDX_W-1:0] snp_idx,
    input  logic [TAG_W-1:0] snp_tag,
    output logic             snp_flush,
    output logic             snp_abort,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [2:0]       dbg_state
);
    localparam logic [2:0] ST_I = 3'b001;
    localparam logic [2:0] ST_S = 3'b010;
    localparam logic [2:0] ST_E = 3'b011;
    localparam logic [2:0] ST_M = 3'b100;

    localparam logic [2:0] CMD_NONE = 3'b000;
    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [2:0] CMD_WR   = 3'b010;
    localparam logic [2:0] CMD_WB   = 3'b011;
    localparam logic [2:0] CMD_INV  = 3'b100;

    typedef enum logic [1:0] {FSM_IDLE, FSM_WB, FSM_REQ} fsm_t;

    fsm_t             r_fsm, w_fsm_nxt;
    logic [2:0]       r_state [NUM_LINES];
    logic [TAG_W-1:0] r_tag   [NUM_LINES];
    logic [2:0]       w_post_state [NUM_LINES];
    logic [2:0]       w_state_nxt  [NUM_LINES];
    logic [TAG_W-1:0] w_tag_nxt    [NUM_LINES];

    logic             r_req_write, w_req_write_nxt;
    logic [IDX_W-1:0] r_req_idx, w_req_idx_nxt;
    logic [TAG_W-1:0] r_req_tag, w_req_tag_nxt;
    logic             r_bus_req, w_bus_req_nxt;
    logic [2:0]       r_bus_cmd, w_bus_cmd_nxt;
    logic [IDX_W-1:0] r_bus_idx, w_bus_idx_nxt;
    logic [TAG_W-1:0] r_bus_tag, w_bus_tag_nxt;
    logic             r_cpu_ready, w_cpu_ready_nxt;
    logic             r_cpu_hit, w_cpu_hit_nxt;
    logic             r_snp_flush, w_snp_flush_nxt;
    logic             w_snp_hit;
    logic [2:0]       w_acc_state;
    logic             w_acc_hit;
    logic [2:0]       w_miss_cmd;

    // Snoop pass: produces the post-snoop line states the requester FSM works from.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_snp_flush_nxt = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) w_post_state[i] = r_state[i];
        w_snp_hit = snp_valid && (r_state[snp_idx] != ST_I) && (r_tag[snp_idx] == snp_tag);
        if (w_snp_hit) begin
            case (snp_cmd)
                CMD_RD: begin
                    if (r_state[snp_idx] == ST_M) w_snp_flush_nxt = 1'b1;
                    w_post_state[snp_idx] = ST_S;
                end
                CMD_WR: begin
                    if (r_state[snp_idx] == ST_M) w_snp_flush_nxt = 1'b1;
                    w_post_state[snp_idx] = ST_I;
                end
                CMD_INV: w_post_state[snp_idx] = ST_I;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_req_write_nxt = r_req_write;
        w_req_idx_nxt   = r_req_idx;
        w_req_tag_nxt   = r_req_tag;
        w_bus_req_nxt   = r_bus_req;
        w_bus_cmd_nxt   = r_bus_cmd;
        w_bus_idx_nxt   = r_bus_idx;
        w_bus_tag_nxt   = r_bus_tag;
        w_cpu_ready_nxt = 1'b0;
        w_cpu_hit_nxt   = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            w_state_nxt[i] = w_post_state[i];
            w_tag_nxt[i]   = r_tag[i];
        end
        w_acc_state = w_post_state[cpu_idx];
        w_acc_hit   = (w_acc_state != ST_I) && (r_tag[cpu_idx] == cpu_tag);
        w_miss_cmd  = r_req_write ? CMD_WR : CMD_RD;

        case (r_fsm)
            FSM_IDLE: begin
                if (cpu_valid && !r_cpu_ready) begin
                    w_req_write_nxt = cpu_write;
                    w_req_idx_nxt   = cpu_idx;
                    w_req_tag_nxt   = cpu_tag;
                    w_bus_idx_nxt   = cpu_idx;
                    w_bus_tag_nxt   = cpu_tag;
                    if (w_acc_hit && (!cpu_write || w_acc_state != ST_S)) begin
                        if (cpu_write) w_state_nxt[cpu_idx] = ST_M;
                        w_cpu_ready_nxt = 1'b1;
                        w_cpu_hit_nxt   = 1'b1;
                    end else if (w_acc_hit) begin
                        w_fsm_nxt     = FSM_REQ;
                        w_bus_req_nxt = 1'b1;
                        w_bus_cmd_nxt = CMD_INV;
                    end else if (w_acc_state == ST_M) begin
                        w_fsm_nxt     = FSM_WB;
                        w_bus_req_nxt = 1'b1;
                        w_bus_cmd_nxt = CMD_WB;
                        w_bus_tag_nxt = r_tag[cpu_idx];
                    end else begin
                        w_fsm_nxt     = FSM_REQ;
                        w_bus_req_nxt = 1'b1;
                        w_bus_cmd_nxt = cpu_write ? CMD_WR : CMD_RD;
                    end
                end
            end
            FSM_WB: begin
                // A snoop that already flushed or dropped the victim makes the write-back moot.
                if (bus_gnt || (w_post_state[r_req_idx] != ST_M)) begin
                    w_state_nxt[r_req_idx] = bus_gnt ? ST_I : w_post_state[r_req_idx];
                    w_fsm_nxt     = FSM_REQ;
                    w_bus_cmd_nxt = w_miss_cmd;
                    w_bus_tag_nxt = r_req_tag;
                end
            end
            FSM_REQ: begin
                if (bus_gnt) begin
                    w_tag_nxt[r_req_idx]   = r_req_tag;
                    w_state_nxt[r_req_idx] = (r_bus_cmd == CMD_RD) ? (bus_shared ? ST_S : ST_E) : ST_M;
                    w_cpu_ready_nxt = 1'b1;
                    w_cpu_hit_nxt   = (r_bus_cmd == CMD_INV);
                    w_fsm_nxt       = FSM_IDLE;
                    w_bus_req_nxt   = 1'b0;
                    w_bus_cmd_nxt   = CMD_NONE;
                    w_bus_idx_nxt   = '0;
                    w_bus_tag_nxt   = '0;
                end else if (r_bus_cmd == CMD_INV && w_post_state[r_req_idx] == ST_I) begin
                    w_bus_cmd_nxt = CMD_WR;
                end
            end
            default: w_fsm_nxt = FSM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
        if (CLR) r_fsm <= FSM_IDLE;
        else     r_fsm <= w_fsm_nxt;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            // NOTE: the line array is reset explicitly because a cold cache must report every line Invalid.
            for (int i = 0; i < NUM_LINES; i++) begin
                r_state[i] <= ST_I;
                r_tag[i]   <= '0;
            end
            r_req_write <= 1'b0;
            r_req_idx   <= '0;
            r_req_tag   <= '0;
            r_bus_req   <= 1'b0;
            r_bus_cmd   <= CMD_NONE;
            r_bus_idx   <= '0;
            r_bus_tag   <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_hit   <= 1'b0;
            r_snp_flush <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_tag[i]   <= w_tag_nxt[i];
            end
            r_req_write <= w_req_write_nxt;
            r_req_idx   <= w_req_idx_nxt;
            r_req_tag   <= w_req_tag_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_cmd   <= w_bus_cmd_nxt;
            r_bus_idx   <= w_bus_idx_nxt;
            r_bus_tag   <= w_bus_tag_nxt;
            r_cpu_ready <= w_cpu_ready_nxt;
            r_cpu_hit   <= w_cpu_hit_nxt;
            r_snp_flush <= w_snp_flush_nxt;
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign cpu_hit   = r_cpu_hit;
    assign bus_req   = r_bus_req;
    assign bus_cmd   = r_bus_cmd;
    assign bus_idx   = r_bus_idx;
    assign bus_tag   = r_bus_tag;
    assign snp_flush = r_snp_flush;
    assign snp_abort = r_snp_flush;
    assign dbg_state = r_state[dbg_idx];

endmodule

// File: tb/tb_mesi_line_array.sv
// Directed bench for mesi_line_array: CPU misses/hits, write-back, upgrade races,
// snoop flushes and mid-transaction reset, all with hand-computed expectations.
module tb_mesi_line_array;
    localparam int NUM_LINES = 4;
    localparam int IDX_W     = 2;
    localparam int TAG_W     = 8;

    logic             CLK = 1'b0;
    logic             CLR;
    logic             cpu_valid, cpu_write;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic             cpu_ready, cpu_hit;
    logic             bus_req;
    logic [2:0]       bus_cmd;
    logic [IDX_W-1:0] bus_idx;
    logic [TAG_W-1:0] bus_tag;
    logic             bus_gnt, bus_shared;
    logic             snp_valid;
    logic [2:0]       snp_cmd;
    logic [IDX_W-1:0] snp_idx;
    logic [TAG_W-1:0] snp_tag;
    logic             snp_flush, snp_abort;
    logic [IDX_W-1:0] dbg_idx;
    logic [2:0]       dbg_state;

    int checks   = 0;
    int failures = 0;

    mesi_line_array #(.NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .CLR(CLR),
        .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_idx(cpu_idx), .cpu_tag(cpu_tag),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
        .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_idx(bus_idx), .bus_tag(bus_tag),
        .bus_gnt(bus_gnt), .bus_shared(bus_shared),
        .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_idx(snp_idx), .snp_tag(snp_tag),
        .snp_flush(snp_flush), .snp_abort(snp_abort),
        .dbg_idx(dbg_idx), .dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        assert (!(snp_valid && bus_gnt)) else $error("illegal snoop/grant overlap in stimulus");

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input int idx, input logic [2:0] exp);
        dbg_idx = IDX_W'(idx);
        #1;
        check(tag, {29'd0, dbg_state}, {29'd0, exp});
    endtask

    task automatic cpu_req(input logic wr, input int idx, input logic [7:0] tag);
        cpu_valid = 1'b1;
        cpu_write = wr;
        cpu_idx   = IDX_W'(idx);
        cpu_tag   = tag;
    endtask

    task automatic snoop(input logic [2:0] cmd, input int idx, input logic [7:0] tag);
        snp_valid = 1'b1;
        snp_cmd   = cmd;
        snp_idx   = IDX_W'(idx);
        snp_tag   = tag;
    endtask

    initial begin
        CLR = 1'b1; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_idx = '0; cpu_tag = '0;
        bus_gnt = 1'b0; bus_shared = 1'b0; snp_valid = 1'b0; snp_cmd = '0; snp_idx = '0;
        snp_tag = '0; dbg_idx = '0;
        tick(); tick();
        CLR = 1'b0;

        // Reset state
        check("rst_ready", cpu_ready, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_cmd", bus_cmd, 0);
        check("rst_flush", snp_flush, 0);
        for (int i = 0; i < NUM_LINES; i++) check_line($sformatf("rst_line%0d", i), i, 3'b001);

        // Read miss idx1 tag 0x12, exclusive; grant after three cycles
        cpu_req(1'b0, 1, 8'h12);
        tick();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rdmiss_req_c%0d", c), bus_req, 1);
            check($sformatf("rdmiss_cmd_c%0d", c), bus_cmd, 3'b001);
            check($sformatf("rdmiss_idx_c%0d", c), bus_idx, 1);
            check($sformatf("rdmiss_tag_c%0d", c), bus_tag, 8'h12);
            check($sformatf("rdmiss_noready_c%0d", c), cpu_ready, 0);
            if (c == 2) begin bus_gnt = 1'b1; bus_shared = 1'b0; end
            tick();
        end
        bus_gnt = 1'b0;
        check("rdmiss_ready", cpu_ready, 1);
        check("rdmiss_hit", cpu_hit, 0);
        check("rdmiss_busreq_drop", bus_req, 0);
        check_line("rdmiss_line1_E", 1, 3'b011);
        cpu_valid = 1'b0;
        tick();
        check("rdmiss_ready_pulse", cpu_ready, 0);

        // Read hit, then write hit with the request held through the ready cycle
        cpu_req(1'b0, 1, 8'h12);
        tick();
        check("rdhit_ready", cpu_ready, 1);
        check("rdhit_hit", cpu_hit, 1);
        check("rdhit_nobus", bus_req, 0);
        cpu_req(1'b1, 1, 8'h12);
        tick();
        check("wrhit_blocked_in_ready_cycle", cpu_ready, 0);
        tick();
        check("wrhit_ready", cpu_ready, 1);
        check("wrhit_hit", cpu_hit, 1);
        check("wrhit_nobus", bus_req, 0);
        check_line("wrhit_line1_M", 1, 3'b100);
        cpu_valid = 1'b0;
        tick();

        // Miss over a Modified victim: write-back of old tag, then read miss (shared)
        cpu_req(1'b0, 1, 8'h34);
        tick();
        check("wb_req", bus_req, 1);
        check("wb_cmd", bus_cmd, 3'b011);
        check("wb_tag", bus_tag, 8'h12);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check("wb_then_req", bus_req, 1);
        check("wb_then_cmd", bus_cmd, 3'b001);
        check("wb_then_tag", bus_tag, 8'h34);
        check("wb_noready", cpu_ready, 0);
        check_line("wb_victim_I", 1, 3'b001);
        tick();
        bus_gnt = 1'b1; bus_shared = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_shared = 1'b0; cpu_valid = 1'b0;
        check("wbrd_ready", cpu_ready, 1);
        check("wbrd_hit", cpu_hit, 0);
        check_line("wbrd_line1_S", 1, 3'b010);
        tick();

        // Line2 Shared tag 0x05, then write upgrade lost to a snooped write miss
        cpu_req(1'b0, 2, 8'h05);
        tick();
        bus_gnt = 1'b1; bus_shared = 1'b1;
        tick();
        bus_gnt = 1'b0; bus_shared = 1'b0; cpu_valid = 1'b0;
        check_line("l2_S", 2, 3'b010);
        tick();
        cpu_req(1'b1, 2, 8'h05);
        tick();
        check("upg_req", bus_req, 1);
        check("upg_cmd", bus_cmd, 3'b100);
        check("upg_idx", bus_idx, 2);
        snoop(3'b010, 2, 8'h05);
        tick();
        snp_valid = 1'b0;
        check("upg_lost_cmd", bus_cmd, 3'b010);
        check("upg_lost_req", bus_req, 1);
        check("upg_lost_noflush", snp_flush, 0);
        check_line("upg_lost_line2_I", 2, 3'b001);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; cpu_valid = 1'b0;
        check("upg_lost_ready", cpu_ready, 1);
        check("upg_lost_hit", cpu_hit, 0);
        check_line("upg_lost_line2_M", 2, 3'b100);
        tick();

        // Line0 Modified tag 0xAA via write miss, then snoop reads
        cpu_req(1'b1, 0, 8'hAA);
        tick();
        check("wrmiss_cmd", bus_cmd, 3'b010);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; cpu_valid = 1'b0;
        check("wrmiss_ready", cpu_ready, 1);
        check_line("wrmiss_line0_M", 0, 3'b100);
        snoop(3'b001, 0, 8'hAB);
        tick();
        check("snp_tagmiss_noflush", snp_flush, 0);
        check_line("snp_tagmiss_line0_M", 0, 3'b100);
        snoop(3'b001, 0, 8'hAA);
        tick();
        snp_valid = 1'b0;
        check("snp_rd_flush", snp_flush, 1);
        check("snp_rd_abort", snp_abort, 1);
        check_line("snp_rd_line0_S", 0, 3'b010);
        tick();
        check("snp_flush_pulse", snp_flush, 0);
        check("snp_abort_pulse", snp_abort, 0);
        snoop(3'b001, 0, 8'hAB);
        tick();
        snp_valid = 1'b0;
        check("snp_tagmiss2_noflush", snp_flush, 0);
        check_line("snp_tagmiss2_line0_S", 0, 3'b010);

        // Pending write-back overtaken by a snoop flush of the victim
        cpu_req(1'b0, 2, 8'h06);
        tick();
        check("wbskip_cmd", bus_cmd, 3'b011);
        check("wbskip_tag", bus_tag, 8'h05);
        snoop(3'b010, 2, 8'h05);
        tick();
        snp_valid = 1'b0;
        check("wbskip_flush", snp_flush, 1);
        check("wbskip_cmd_rd", bus_cmd, 3'b001);
        check("wbskip_tag_new", bus_tag, 8'h06);
        check_line("wbskip_line2_I", 2, 3'b001);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0; cpu_valid = 1'b0;
        check("wbskip_ready", cpu_ready, 1);
        check_line("wbskip_line2_E", 2, 3'b011);
        tick();

        // Reset while a read miss is waiting in REQ
        cpu_req(1'b0, 3, 8'h77);
        tick();
        check("midrst_req_before", bus_req, 1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0; cpu_valid = 1'b0;
        check("midrst_req_dropped", bus_req, 0);
        check("midrst_cmd", bus_cmd, 0);
        for (int i = 0; i < NUM_LINES; i++) check_line($sformatf("midrst_line%0d", i), i, 3'b001);
        tick();
        check("midrst_discarded_req", bus_req, 0);
        check("midrst_discarded_ready", cpu_ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
